// File: rtl/rv32i_decode.sv
// rtl/rv32i_decode.sv - combinational RV32I instruction decoder with next-PC resolution
module rv32i_decode #(
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    branch,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    branch_op,
  output logic [31:0]             imm32,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic                    mem_wEn,
  output logic                    wb_sel
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic       raw_wen, raw_mem_wen, raw_branch_op, raw_next_sel;

  // Decoder holds no state; clock and JALR_target bit 0 are deliberately not consumed.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clock, JALR_target[0]};

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign read_sel1 = instruction[19:15];
  assign read_sel2 = instruction[24:20];
  assign write_sel = instruction[11:7];

  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_sh = {27'b0, instruction[24:20]};
  assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u  = {instruction[31:12], 12'b0};
  assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

  // Per-opcode immediate, operand selects, ALU code and raw enables.
  always_comb begin
    imm32         = 32'b0;
    op_A_sel      = 2'b00;
    op_B_sel      = 1'b0;
    ALU_Control   = 6'b000000;
    raw_wen       = 1'b0;
    raw_mem_wen   = 1'b0;
    raw_branch_op = 1'b0;
    wb_sel        = 1'b0;
    case (opcode)
      OP_R: begin
        raw_wen     = 1'b1;
        ALU_Control = {2'b00, instruction[30], funct3};
      end
      OP_I: begin
        raw_wen  = 1'b1;
        op_B_sel = 1'b1;
        // Shift-immediates carry only a 5-bit shamt; inst[30] picks srai vs srli.
        if (funct3 == 3'b001 || funct3 == 3'b101) imm32 = imm_sh;
        else                                      imm32 = imm_i;
        if (funct3 == 3'b101) ALU_Control = {2'b00, instruction[30], 3'b101};
        else                  ALU_Control = {3'b000, funct3};
      end
      OP_LOAD: begin
        raw_wen  = 1'b1;
        op_B_sel = 1'b1;
        wb_sel   = 1'b1;
        imm32    = imm_i;
      end
      OP_STORE: begin
        raw_mem_wen = 1'b1;
        op_B_sel    = 1'b1;
        imm32       = imm_s;
      end
      OP_BRANCH: begin
        raw_branch_op = 1'b1;
        imm32         = imm_b;
        ALU_Control   = {3'b010, funct3};
      end
      OP_JALR: begin
        raw_wen     = 1'b1;
        op_A_sel    = 2'b10;
        imm32       = imm_i;
        ALU_Control = 6'b111111;
      end
      OP_JAL: begin
        raw_wen     = 1'b1;
        op_A_sel    = 2'b10;
        imm32       = imm_j;
        ALU_Control = 6'b011111;
      end
      OP_AUIPC: begin
        raw_wen  = 1'b1;
        op_A_sel = 2'b01;
        op_B_sel = 1'b1;
        imm32    = imm_u;
      end
      OP_LUI: begin
        raw_wen  = 1'b1;
        op_A_sel = 2'b11;
        op_B_sel = 1'b1;
        imm32    = imm_u;
      end
      default: ;
    endcase
  end

  // Next-PC choice and destination; PC-relative targets wrap at the PC width.
  always_comb begin
    raw_next_sel = 1'b0;
    target_PC    = PC + ADDRESS_BITS'(4);
    case (opcode)
      OP_JAL: begin
        raw_next_sel = 1'b1;
        target_PC    = PC + imm_j[ADDRESS_BITS-1:0];
      end
      OP_JALR: begin
        raw_next_sel = 1'b1;
        target_PC    = {JALR_target[ADDRESS_BITS-1:1], 1'b0};
      end
      OP_BRANCH: begin
        raw_next_sel = branch;
        target_PC    = PC + imm_b[ADDRESS_BITS-1:0];
      end
      default: ;
    endcase
  end

  // Reset gates only the side-effecting controls, and does so without waiting for a clock.
  assign wEn            = reset & raw_wen;
  assign mem_wEn        = reset & raw_mem_wen;
  assign branch_op      = reset & raw_branch_op;
  assign next_PC_select = reset & raw_next_sel;

endmodule

// File: tb/tb_rv32i_decode.sv
// tb/tb_rv32i_decode.sv - directed self-checking bench for rv32i_decode
module tb_rv32i_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] PC;
  logic [31:0] instruction;
  logic [15:0] JALR_target;
  logic        branch;
  logic        next_PC_select;
  logic [15:0] target_PC;
  logic [4:0]  read_sel1, read_sel2, write_sel;
  logic        wEn, branch_op, op_B_sel, mem_wEn, wb_sel;
  logic [31:0] imm32;
  logic [1:0]  op_A_sel;
  logic [5:0]  ALU_Control;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rv32i_decode #(.ADDRESS_BITS(16)) dut (
    .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
    .JALR_target(JALR_target), .branch(branch),
    .next_PC_select(next_PC_select), .target_PC(target_PC),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
    .wEn(wEn), .branch_op(branch_op), .imm32(imm32), .op_A_sel(op_A_sel),
    .op_B_sel(op_B_sel), .ALU_Control(ALU_Control), .mem_wEn(mem_wEn),
    .wb_sel(wb_sel)
  );

  task automatic apply(input logic [15:0] pc, input logic [31:0] inst,
                       input logic [15:0] jt, input logic br);
    @(negedge clock);
    PC = pc; instruction = inst; JALR_target = jt; branch = br;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    apply(16'h0114, 32'h0140006F, 16'h0000, 1'b1);
    checks++; if (next_PC_select !== 1'b0) begin errors++; $display("FAIL reset_npc got %b want 0", next_PC_select); end
    checks++; if (wEn !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", wEn); end
    checks++; if (target_PC !== 16'h0128) begin errors++; $display("FAIL reset_target got %h want 0128", target_PC); end
    apply(16'h0000, 32'h00C5A023, 16'h0000, 1'b0);
    checks++; if (mem_wEn !== 1'b0) begin errors++; $display("FAIL reset_memwen got %b want 0", mem_wEn); end
    apply(16'h0094, 32'h00C58863, 16'h0000, 1'b1);
    checks++; if ({branch_op, next_PC_select} !== 2'b00) begin errors++; $display("FAIL reset_branch got %b want 00", {branch_op, next_PC_select}); end
    checks++; if (ALU_Control !== 6'b010000) begin errors++; $display("FAIL reset_alu got %b want 010000", ALU_Control); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_itype;
    apply(16'h0000, 32'hFFF00593, 16'h0000, 1'b0);
    checks++; if (write_sel !== 5'd11) begin errors++; $display("FAIL addi_rd got %0d want 11", write_sel); end
    checks++; if (wEn !== 1'b1) begin errors++; $display("FAIL addi_wen got %b want 1", wEn); end
    checks++; if (imm32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", imm32); end
    checks++; if ({op_B_sel, ALU_Control} !== 7'b1_000000) begin errors++; $display("FAIL addi_ctl got %b want 1000000", {op_B_sel, ALU_Control}); end
    checks++; if (target_PC !== 16'h0004 || next_PC_select !== 1'b0) begin errors++; $display("FAIL addi_pc got %h/%b want 0004/0", target_PC, next_PC_select); end
    apply(16'h0000, 32'h41F5D613, 16'h0000, 1'b0);
    checks++; if (ALU_Control !== 6'b001101) begin errors++; $display("FAIL srai_alu got %b want 001101", ALU_Control); end
    checks++; if (imm32 !== 32'd31) begin errors++; $display("FAIL srai_imm got %h want 0000001f", imm32); end
  endtask

  task automatic test_rtype;
    apply(16'h0000, 32'h40E608B3, 16'h0000, 1'b0);
    checks++; if ({read_sel1, read_sel2, write_sel} !== {5'd12, 5'd14, 5'd17}) begin errors++; $display("FAIL sub_sel got %0d/%0d/%0d want 12/14/17", read_sel1, read_sel2, write_sel); end
    checks++; if (ALU_Control !== 6'b001000) begin errors++; $display("FAIL sub_alu got %b want 001000", ALU_Control); end
    checks++; if ({op_B_sel, imm32} !== 33'd0) begin errors++; $display("FAIL sub_opb got %b/%h want 0/0", op_B_sel, imm32); end
    apply(16'h0000, 32'h00E628B3, 16'h0000, 1'b0);
    checks++; if (ALU_Control !== 6'b000010) begin errors++; $display("FAIL slt_alu got %b want 000010", ALU_Control); end
  endtask

  task automatic test_mem;
    apply(16'h0000, 32'h00C5A023, 16'h0000, 1'b0);
    checks++; if ({mem_wEn, wEn, wb_sel} !== 3'b100) begin errors++; $display("FAIL sw_en got %b want 100", {mem_wEn, wEn, wb_sel}); end
    checks++; if (imm32 !== 32'd0 || op_B_sel !== 1'b1) begin errors++; $display("FAIL sw_imm got %h/%b want 0/1", imm32, op_B_sel); end
    apply(16'h0000, 32'h0005A903, 16'h0000, 1'b0);
    checks++; if ({wb_sel, wEn, mem_wEn} !== 3'b110) begin errors++; $display("FAIL lw_en got %b want 110", {wb_sel, wEn, mem_wEn}); end
    checks++; if (write_sel !== 5'd18) begin errors++; $display("FAIL lw_rd got %0d want 18", write_sel); end
  endtask

  task automatic test_jumps;
    apply(16'h0114, 32'h0140006F, 16'h0000, 1'b0);
    checks++; if (next_PC_select !== 1'b1) begin errors++; $display("FAIL jal_npc got %b want 1", next_PC_select); end
    checks++; if (target_PC !== 16'h0128) begin errors++; $display("FAIL jal_target got %h want 0128", target_PC); end
    checks++; if ({op_A_sel, ALU_Control} !== 8'b10_011111) begin errors++; $display("FAIL jal_ctl got %b want 10011111", {op_A_sel, ALU_Control}); end
    apply(16'h0000, 32'h0C4080E7, 16'h0154, 1'b0);
    checks++; if (target_PC !== 16'h0154 || next_PC_select !== 1'b1) begin errors++; $display("FAIL jalr_target got %h/%b want 0154/1", target_PC, next_PC_select); end
    checks++; if (imm32 !== 32'd196) begin errors++; $display("FAIL jalr_imm got %0d want 196", imm32); end
    checks++; if ({ALU_Control, wEn} !== 7'b111111_1) begin errors++; $display("FAIL jalr_ctl got %b want 1111111", {ALU_Control, wEn}); end
    apply(16'h0000, 32'h0C4080E7, 16'h0155, 1'b0);
    checks++; if (target_PC !== 16'h0154) begin errors++; $display("FAIL jalr_lsb got %h want 0154", target_PC); end
  endtask

  task automatic test_branch;
    apply(16'h0094, 32'h00C58863, 16'h0000, 1'b1);
    checks++; if (next_PC_select !== 1'b1 || target_PC !== 16'h00A4) begin errors++; $display("FAIL beq_taken got %b/%h want 1/00a4", next_PC_select, target_PC); end
    checks++; if ({branch_op, ALU_Control, wEn} !== 8'b1_010000_0) begin errors++; $display("FAIL beq_ctl got %b want 10100000", {branch_op, ALU_Control, wEn}); end
    apply(16'h0094, 32'h00C58863, 16'h0000, 1'b0);
    checks++; if (next_PC_select !== 1'b0) begin errors++; $display("FAIL beq_nottaken got %b want 0", next_PC_select); end
    apply(16'h0000, 32'hFE001EE3, 16'h0000, 1'b1);
    checks++; if (target_PC !== 16'hFFFC || imm32 !== 32'hFFFFFFFC) begin errors++; $display("FAIL bne_wrap got %h/%h want fffc/fffffffc", target_PC, imm32); end
    checks++; if (ALU_Control !== 6'b010001) begin errors++; $display("FAIL bne_alu got %b want 010001", ALU_Control); end
  endtask

  task automatic test_upper_unknown;
    apply(16'h0000, 32'hFFFFF5B7, 16'h0000, 1'b0);
    checks++; if (imm32 !== 32'hFFFFF000) begin errors++; $display("FAIL lui_imm got %h want fffff000", imm32); end
    checks++; if ({op_A_sel, op_B_sel, wEn} !== 4'b11_1_1) begin errors++; $display("FAIL lui_ctl got %b want 1111", {op_A_sel, op_B_sel, wEn}); end
    apply(16'h0011, 32'h00000517, 16'h0000, 1'b0);
    checks++; if (op_A_sel !== 2'b01 || target_PC !== 16'h0015) begin errors++; $display("FAIL auipc got %b/%h want 01/0015", op_A_sel, target_PC); end
    apply(16'h0020, 32'hFFFFFFFF, 16'h0000, 1'b1);
    checks++; if ({wEn, mem_wEn, branch_op, next_PC_select, wb_sel, op_B_sel, op_A_sel} !== 8'd0) begin errors++; $display("FAIL unk_ctl got %b want 00000000", {wEn, mem_wEn, branch_op, next_PC_select, wb_sel, op_B_sel, op_A_sel}); end
    checks++; if (imm32 !== 32'd0 || ALU_Control !== 6'd0) begin errors++; $display("FAIL unk_imm got %h/%b want 0/000000", imm32, ALU_Control); end
    checks++; if (target_PC !== 16'h0024) begin errors++; $display("FAIL unk_pc got %h want 0024", target_PC); end
  endtask

  initial begin
    reset = 1'b1; PC = '0; instruction = '0; JALR_target = '0; branch = 1'b0;
    test_reset;
    test_itype;
    test_rtype;
    test_mem;
    test_jumps;
    test_branch;
    test_upper_unknown;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
